// File: rtl/riscv_pkg.sv
// RISC-V shared definitions: M-extension funct3 encodings, the multiply/divide
// unit state encoding and helpers that classify operand signedness per op.
package riscv_pkg;

  // M-extension funct3 field (funct7 = MULDIV_FUNCT7)
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_funct3_t;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } muldiv_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // rs1 is treated as two's complement for these ops
  function automatic logic rs1_is_signed(input logic [2:0] f);
    return (f == MUL) || (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic rs2_is_signed(input logic [2:0] f);
    return (f == MUL) || (f == MULH) || (f == DIV) || (f == REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_sign_fix.sv
// Sign handling for the multiply/divide unit. The capture side turns raw
// operands into magnitudes plus sign flags; the finish side re-applies the
// result signs and picks the word the op asks for.
module riscv_muldiv_sign_fix
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   rs1_mag,
  output logic [XLEN-1:0]   rs2_mag,
  output logic              rs1_neg,
  output logic              rs2_neg,
  input  logic [2:0]        fin_op,
  input  logic              res_neg,
  input  logic              rem_neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    rs1_neg = rs1_is_signed(op) & rs1[XLEN-1];
    rs2_neg = rs2_is_signed(op) & rs2[XLEN-1];
    rs1_mag = rs1_neg ? -rs1 : rs1;
    rs2_mag = rs2_neg ? -rs2 : rs2;
  end

  // Result sign restore and word selection
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    result   = '0;
    prod_fix = res_neg ? -prod : prod;
    quo_fix  = res_neg ? -quo  : quo;
    rem_fix  = rem_neg ? -rem  : rem;
    case (fin_op)
      MUL:                 result = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: result = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           result = quo_fix;
      REM, REMU:           result = rem_fix;
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide share one accumulator pair, counter and FSM.
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies with a single
// combinational product in FIN instead of iterating.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state;
  logic [CNT_W-1:0] cnt;
  m_funct3_t       op_q;
  logic            res_neg_q;
  logic            rem_neg_q;
  // acc_q: product high half / partial remainder
  // lo_q : multiplier shifting out + product low half / dividend shifting
  //        out + quotient shifting in
  // b_q  : multiplicand / divisor magnitude
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;

  logic            accept;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_acc_nx;
  logic [XLEN-1:0] mul_lo_nx;
  logic [XLEN:0]   rem_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_acc_nx;
  logic [XLEN-1:0] div_lo_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] fin_result;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  // Single-cycle product of the captured magnitudes; sign restored in FIN
  assign prod = {{XLEN{1'b0}}, b_q} * {{XLEN{1'b0}}, lo_q};
`else
  localparam bit FAST_MUL = 1'b0;
  assign prod = {acc_q, lo_q};
`endif

  riscv_muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_mag (rs1_mag),
    .rs2_mag (rs2_mag),
    .rs1_neg (rs1_neg),
    .rs2_neg (rs2_neg),
    .fin_op  (op_q),
    .res_neg (res_neg_q),
    .rem_neg (rem_neg_q),
    .prod    (prod),
    .quo     (lo_q),
    .rem     (acc_q),
    .result  (fin_result)
  );

  // Accept qualification and divide special-case detection
  always_comb begin
    accept   = in_valid && in_ready && !flush;
    div_zero = (rs2 == '0);
    div_ovf  = ((op == DIV) || (op == REM)) && (rs1 == MOST_NEG) && (&rs2);
    special  = op_is_div(op) && (div_zero || div_ovf);
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mul_acc_nx = mul_sum[XLEN:1];
    mul_lo_nx  = {mul_sum[0], lo_q[XLEN-1:1]};
    rem_sh     = {acc_q, lo_q[XLEN-1]};
    div_ge     = (rem_sh >= {1'b0, b_q});
    // When the trial subtraction succeeds the difference is below b_q, so
    // the low XLEN bits of the wrap-around subtraction are exact.
    div_acc_nx = div_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    div_lo_nx  = {lo_q[XLEN-2:0], div_ge};
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset along with the control state so
    // a fresh unit starts from a known accumulator and a zero out_result.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= MUL;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      acc_q      <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of the others.
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= m_funct3_t'(op);
            cnt      <= '0;
            in_ready <= 1'b0;
            if (special) begin
              // Preload the final quotient (lo) and remainder (acc) so FIN
              // just selects them with no sign correction.
              state     <= FIN;
              res_neg_q <= 1'b0;
              rem_neg_q <= 1'b0;
              lo_q      <= div_zero ? {XLEN{1'b1}} : rs1;
              acc_q     <= div_zero ? rs1 : '0;
            end else begin
              res_neg_q <= rs1_neg ^ rs2_neg;
              rem_neg_q <= rs1_neg;
              acc_q     <= '0;
              if (op_is_div(op)) begin
                lo_q  <= rs1_mag;
                b_q   <= rs2_mag;
                state <= CALC;
              end else begin
                lo_q  <= rs2_mag;
                b_q   <= rs1_mag;
                state <= FAST_MUL ? FIN : CALC;
              end
            end
          end
        end
        CALC: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            if (op_is_div(op_q)) begin
              acc_q <= div_acc_nx;
              lo_q  <= div_lo_nx;
            end else begin
              acc_q <= mul_acc_nx;
              lo_q  <= mul_lo_nx;
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          if (!flush) begin
            out_valid  <= 1'b1;
            out_result <= fin_result;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in XLEN.
- Executes all eight M-extension funct3 operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage. The core stalls on in_ready low and takes the result when out_valid pulses.
- Radix-2 shift-add multiply and restoring divide share one datapath, counter and FSM.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request; accepted on a clk edge when in_valid && in_ready.
- in_ready  output  1  high only in IDLE.
- op  input  3  M-extension funct3 (package m_funct3 enum).
- rs1  input  XLEN  dividend / multiplicand.
- rs2  input  XLEN  divisor / multiplier.
- flush  input  1  abort the in-flight operation (pipeline kill).
- out_valid  output  1  one-cycle pulse; out_result is valid in that cycle.
- out_result  output  XLEN  result; holds its value until the next completion.

Behaviour:
- Reset: async on rst high; state=IDLE; in_ready=1; out_valid=0; out_result=0; counter and accumulators cleared.
- Reset mid-operation: the operation is discarded and no out_valid is produced.
- FSM states: IDLE, CALC, FIN.
  - IDLE -> CALC on accept.
  - IDLE -> FIN directly on a special-case divide (see below).
  - CALC -> FIN after XLEN iterations.
  - FIN -> IDLE always. FIN drives out_valid=1 for exactly one cycle.
- Operand capture at accept:
  - Record the sign of each operand per op: MULH signs both; MULHSU signs rs1 only; MULHU, DIVU, REMU are unsigned.
  - Store magnitudes.
  - Latch op; in_valid/op/rs* are don't-care afterwards.
- Multiply: 2*XLEN product register, one bit per cycle for XLEN cycles.
  - In FIN: negate if sign(rs1) XOR sign(rs2).
  - Select the low half (MUL) or the high half (MULH*).
- Divide: restoring, one quotient bit per cycle for XLEN cycles.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - DIV/REM round toward zero.
- Latency, normal ops: accept edge E; out_valid high in the cycle after edge E+XLEN+1 (XLEN+1 edges; 33 for XLEN=32).
- Special cases, decided at accept; go straight to FIN, out_valid after edge E+1:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV result = rs1; REM result = 0.
- in_valid while in_ready=0: ignored, no queuing. The requester must hold the request.
- flush:
  - In CALC or FIN: return to IDLE next edge, suppress out_valid, keep out_result unchanged.
  - In IDLE: blocks the accept in that cycle.
  - flush and out_valid in the same cycle: flush wins (no pulse).
- No back-pressure on output: the consumer must take the result in the out_valid cycle.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a combinational 2*XLEN signed-extended product registered in FIN. MUL* latency = 1 edge (accept -> FIN); divide path unchanged.
- Undefined: multiply is iterative as above; no hardware multiplier is inferred.

Decomposition:
- riscv_pkg additions:
  - m_funct3 enum (3-bit: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111).
  - Constant MULDIV_FUNCT7 = 7'b0000001.
  - muldiv_state_t enum {IDLE, CALC, FIN}.
- Sub-module: riscv_muldiv_sign_fix. Combinational magnitude/negate and signed result selection, shared by the capture and FIN logic. The FSM and datapath stay in the top.

Test Plan (XLEN=32):
- MUL rs1=7, rs2=0xFFFFFFFD -> out_result=0xFFFFFFEB; out_valid exactly 33 edges after accept; in_ready low throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed rounding: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Special cases, all with out_valid one edge after accept: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Abort and reset:
  - flush at edge 10 of a DIV -> no out_valid; in_ready=1 next cycle; out_result retains its prior value.
  - in_valid pulsed while busy -> ignored.
  - rst at edge 5 -> all outputs at reset values immediately.
- With MULDIV_FAST_MUL_EN: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB with out_valid one edge after accept; DIVU latency still 33.
